id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline stage directly downstream of the instruction decoder in the 5-stage MIPS core. It registers the decoder's control bundle and the ID-stage operands into the EX stage. It detects load-use hazards between the instruction in EX and the one in ID, inserts a one-cycle bubble and raises a stall to the PC and IF/ID register. It also squashes the ID instruction on a taken-branch flush.

## Interface
- DW, 32, datapath width for register data, immediate and PC+4
- CNT_W, 16, width of the bubble performance counter
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- RegWrite_i, ALUSrc_i, RegDst_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i  in  1 each  decoder control bits for the ID instruction
- ALU_op_i  in  3  decoder ALU op
- rs_i, rt_i, rd_i  in  5 each  ID register specifiers
- rs_data_i, rt_data_i  in  DW each  register-file read data
- imm_i  in  DW  sign-extended immediate
- pc4_i  in  DW  PC+4 of the ID instruction
- funct_i  in  6  function field
- flush_i  in  1  taken-branch flush from MEM; kills the ID instruction
- RegWrite_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, MemtoReg_o  out  1 each  registered EX controls
- ALU_op_o  out  3  registered ALU op
- rs_data_o, rt_data_o, imm_o, pc4_o  out  DW each  registered operands
- rs_o, rt_o  out  5 each  registered source specifiers, for forwarding
- wr_reg_o  out  5  registered destination: rd_i if RegDst_i else rt_i
- funct_o  out  6  registered funct
- valid_o  out  1  EX holds a real instruction, not a bubble
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted

## Operation
- Rising-edge update priority: rst_i > flush_i > hazard bubble > normal capture.
- **Normal capture:** every `_o` register loads its corresponding input. wr_reg_o loads the RegDst-selected specifier. valid_o=1.
- **Bubble (flush or hazard):**
  - All control outputs, ALU_op_o, valid_o, wr_reg_o, rs_o and rt_o are set to 0.
  - Data outputs are set to 0.
- **Source-use rule:**
  - rs is always a source.
  - rt is a source iff RegDst_i | MemWrite_i | Branch_i (R-type, sw, beq).
- **hazard:** MemRead_o & valid_o & (wr_reg_o != 0) & ((wr_reg_o == rs_i) | (rt_used & wr_reg_o == rt_i)).
- **stall_o** = hazard & ~flush_i. While stall_o=1, upstream holds its inputs, so the ID instruction is presented again next cycle.
- After a bubble, MemRead_o=0, so stall_o deasserts. Each load-use costs exactly one stall cycle.
- **bubble_cnt_o:**
  - Increments by 1 on each edge where a hazard bubble is inserted, i.e. stall_o=1 at the edge.
  - Does not increment on a flush bubble.
  - Saturates at all-ones. Cleared by reset.
- The block has no FSM beyond the stage register. State is {valid, control bundle, operands, counter}.

## Timing
- Capture latency: 1 cycle from ID inputs to `_o` outputs.
- stall_o is combinational from current ID inputs and registered EX state, in the same cycle. There is no registered path to stall_o.
- Reset: every output is 0, including stall_o, since valid_o=0.
- **Flush and hazard in the same cycle:** the flush wins. stall_o=0, a bubble is inserted, and the counter is unchanged.
- **Reset mid-stall:** the next edge clears everything. stall_o falls in the following cycle.
- Back-to-back lw → lw(use) → use: each dependent load costs one bubble. The counter ends at 2.

## Configuration
- **LOADUSE_HAZARD_EN defined:** detection, stall_o, hazard bubbles and bubble_cnt_o behave as specified above.
- **LOADUSE_HAZARD_EN undefined:**
  - stall_o is tied to 0 and no hazard bubbles are inserted.
  - bubble_cnt_o is tied to 0.
  - flush_i handling is unchanged. Software or forwarding must cover load-use cases.

## Test plan
- **Reset:** drive rst_i=1 for 2 cycles with all inputs nonzero → all outputs 0 and bubble_cnt_o=0.
- **Pass-through:** addi with rs=9, rt=8, imm=5, RegWrite=1, ALUSrc=1, ALU_op=000 → after 1 edge: RegWrite_o=1, ALUSrc_o=1, wr_reg_o=8, imm_o=5, valid_o=1, stall_o=0.
- **Load-use:** lw to rt=8 captured, then ID holds R-type add with rs=8 → stall_o=1 that cycle. The next edge gives valid_o=0, RegWrite_o=0 and bubble_cnt_o=1. Next cycle stall_o=0, and the add is captured with wr_reg_o=rd.
- **Non-hazards:**
  - lw to $0 followed by a use of $0 → stall_o=0.
  - lw to $8 followed by addi with rs=9, rt=8 (rt not a source) → stall_o=0.
- **Flush priority:** load-use condition present together with flush_i=1 → stall_o=0, bubble inserted, bubble_cnt_o unchanged.
- **Macro off:** build without LOADUSE_HAZARD_EN and replay the load-use sequence → stall_o stays 0, the add is captured on the next edge, and bubble_cnt_o=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard bubble/stall and taken-branch flush.
// Optional load-use detection is built only when LOADUSE_HAZARD_EN is defined.
module id_ex_stage #(
   parameter int unsigned DW    = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             RegWrite_i,
   input  logic             ALUSrc_i,
   input  logic             RegDst_i,
   input  logic             Branch_i,
   input  logic             MemRead_i,
   input  logic             MemWrite_i,
   input  logic             MemtoReg_i,
   input  logic [2:0]       ALU_op_i,
   input  logic [4:0]       rs_i,
   input  logic [4:0]       rt_i,
   input  logic [4:0]       rd_i,
   input  logic [DW-1:0]    rs_data_i,
   input  logic [DW-1:0]    rt_data_i,
   input  logic [DW-1:0]    imm_i,
   input  logic [DW-1:0]    pc4_i,
   input  logic [5:0]       funct_i,
   input  logic             flush_i,
   output logic             RegWrite_o,
   output logic             ALUSrc_o,
   output logic             Branch_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             MemtoReg_o,
   output logic [2:0]       ALU_op_o,
   output logic [DW-1:0]    rs_data_o,
   output logic [DW-1:0]    rt_data_o,
   output logic [DW-1:0]    imm_o,
   output logic [DW-1:0]    pc4_o,
   output logic [4:0]       rs_o,
   output logic [4:0]       rt_o,
   output logic [4:0]       wr_reg_o,
   output logic [5:0]       funct_o,
   output logic             valid_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

`ifdef LOADUSE_HAZARD_EN
   logic rt_used;
   logic hazard;

   // rt is read only by R-type, store and branch instructions
   always_comb begin
      rt_used = RegDst_i | MemWrite_i | Branch_i;
      hazard  = MemRead_o & valid_o & (wr_reg_o != 5'd0) &
                ((wr_reg_o == rs_i) | (rt_used & (wr_reg_o == rt_i)));
   end

   assign stall_o = hazard & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         bubble_cnt_o <= '0;
      else if (stall_o && (bubble_cnt_o != '1))
         bubble_cnt_o <= bubble_cnt_o + 1'b1;
   end
`else
   assign stall_o      = 1'b0;
   assign bubble_cnt_o = '0;
`endif

   // Reset, flush and hazard bubble all leave an empty, all-zero EX slot
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i || stall_o) begin
         RegWrite_o <= 1'b0;
         ALUSrc_o   <= 1'b0;
         Branch_o   <= 1'b0;
         MemRead_o  <= 1'b0;
         MemWrite_o <= 1'b0;
         MemtoReg_o <= 1'b0;
         ALU_op_o   <= '0;
         rs_data_o  <= '0;
         rt_data_o  <= '0;
         imm_o      <= '0;
         pc4_o      <= '0;
         rs_o       <= '0;
         rt_o       <= '0;
         wr_reg_o   <= '0;
         funct_o    <= '0;
         valid_o    <= 1'b0;
      end else begin
         RegWrite_o <= RegWrite_i;
         ALUSrc_o   <= ALUSrc_i;
         Branch_o   <= Branch_i;
         MemRead_o  <= MemRead_i;
         MemWrite_o <= MemWrite_i;
         MemtoReg_o <= MemtoReg_i;
         ALU_op_o   <= ALU_op_i;
         rs_data_o  <= rs_data_i;
         rt_data_o  <= rt_data_i;
         imm_o      <= imm_i;
         pc4_o      <= pc4_i;
         rs_o       <= rs_i;
         rt_o       <= rt_i;
         wr_reg_o   <= RegDst_i ? rd_i : rt_i;
         funct_o    <= funct_i;
         valid_o    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table plus randomized run against a reference model.
// Expectations follow LOADUSE_HAZARD_EN the same way the design build does.
module tb_id_ex_stage;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;
`ifdef LOADUSE_HAZARD_EN
   localparam int H = 1;
`else
   localparam int H = 0;
`endif
   localparam int K_ADDI = 0, K_LW = 1, K_ADD = 2, K_SW = 3;

   typedef struct packed {
      logic rst, flush, rw, alusrc, regdst, branch, memread, memwrite, memtoreg;
      logic [2:0] aluop;
      logic [4:0] rs, rt, rd;
      logic [31:0] rsd, rtd, imm, pc4;
      logic [5:0] funct;
   } in_t;

   typedef struct packed {
      logic rw, alusrc, branch, memread, memwrite, memtoreg;
      logic [2:0] aluop;
      logic [31:0] rsd, rtd, imm, pc4;
      logic [4:0] rs, rt, wr;
      logic [5:0] funct;
      logic valid;
   } ex_t;

   typedef struct {
      in_t in;
      logic stall, valid, rw;
      logic [4:0] wr;
      logic [CW-1:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   in_t cur;
   logic RegWrite_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, MemtoReg_o;
   logic [2:0] ALU_op_o;
   logic [31:0] rs_data_o, rt_data_o, imm_o, pc4_o;
   logic [4:0] rs_o, rt_o, wr_reg_o;
   logic [5:0] funct_o;
   logic valid_o, stall_o;
   logic [CW-1:0] bubble_cnt_o;
   ex_t dut_ex;

   id_ex_stage #(.DW(32), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(cur.rst),
      .RegWrite_i(cur.rw), .ALUSrc_i(cur.alusrc), .RegDst_i(cur.regdst),
      .Branch_i(cur.branch), .MemRead_i(cur.memread), .MemWrite_i(cur.memwrite),
      .MemtoReg_i(cur.memtoreg), .ALU_op_i(cur.aluop),
      .rs_i(cur.rs), .rt_i(cur.rt), .rd_i(cur.rd),
      .rs_data_i(cur.rsd), .rt_data_i(cur.rtd), .imm_i(cur.imm), .pc4_i(cur.pc4),
      .funct_i(cur.funct), .flush_i(cur.flush),
      .RegWrite_o(RegWrite_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
      .ALU_op_o(ALU_op_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
      .imm_o(imm_o), .pc4_o(pc4_o), .rs_o(rs_o), .rt_o(rt_o), .wr_reg_o(wr_reg_o),
      .funct_o(funct_o), .valid_o(valid_o), .stall_o(stall_o),
      .bubble_cnt_o(bubble_cnt_o)
   );

   assign dut_ex = {RegWrite_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, MemtoReg_o,
                    ALU_op_o, rs_data_o, rt_data_o, imm_o, pc4_o, rs_o, rt_o, wr_reg_o,
                    funct_o, valid_o};

   int n_chk = 0;
   int n_pass = 0;
   ex_t m_ex;
   int m_cnt;

   task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic in_t mk(input logic rst, input logic flush, input int kind,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] imm);
      in_t i = '0;
      i.rst = rst; i.flush = flush;
      i.rs = rs; i.rt = rt; i.rd = rd; i.imm = imm;
      i.rsd = 32'h1000 + 32'(rs); i.rtd = 32'h2000 + 32'(rt); i.pc4 = 32'h0040_0004;
      case (kind)
         K_ADDI: begin i.rw = 1; i.alusrc = 1; end
         K_LW:   begin i.rw = 1; i.alusrc = 1; i.memread = 1; i.memtoreg = 1; end
         K_ADD:  begin i.rw = 1; i.regdst = 1; i.aluop = 3'd2; i.funct = 6'h20; end
         default: begin i.alusrc = 1; i.memwrite = 1; end
      endcase
      return i;
   endfunction

   function automatic vec_t row(input in_t i, input int s, input int v, input int rw,
                                input int wr, input int cnt);
      vec_t r;
      r.in = i; r.stall = s[0]; r.valid = v[0]; r.rw = rw[0];
      r.wr = wr[4:0]; r.cnt = cnt[CW-1:0];
      return r;
   endfunction

   // Reference: which instruction, if any, occupies EX after each edge
   function automatic logic model_stall(input ex_t e, input in_t i);
      logic reads_rt;
      if (H == 0 || i.flush || !e.valid || !e.memread || e.wr == 5'd0) return 1'b0;
      reads_rt = i.regdst || i.memwrite || i.branch;
      return (e.wr == i.rs) || (reads_rt && e.wr == i.rt);
   endfunction

   function automatic ex_t capture(input in_t i);
      ex_t e;
      e.rw = i.rw; e.alusrc = i.alusrc; e.branch = i.branch; e.memread = i.memread;
      e.memwrite = i.memwrite; e.memtoreg = i.memtoreg; e.aluop = i.aluop;
      e.rsd = i.rsd; e.rtd = i.rtd; e.imm = i.imm; e.pc4 = i.pc4;
      e.rs = i.rs; e.rt = i.rt; e.wr = i.regdst ? i.rd : i.rt;
      e.funct = i.funct; e.valid = 1'b1;
      return e;
   endfunction

   task automatic step(output logic s);
      s = model_stall(m_ex, cur);
      @(posedge clk);
      if (cur.rst) begin
         m_ex = '0; m_cnt = 0;
      end else if (cur.flush) begin
         m_ex = '0;
      end else if (s) begin
         m_ex = '0;
         if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
         m_ex = capture(cur);
      end
      #1;
   endtask

   initial begin
      vec_t tab[$];
      logic s;
      logic held;

      cur = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 200'(dut_ex), 200'(0));
      chk("reset_stall", 200'(stall_o), 200'(0));
      chk("reset_cnt", 200'(bubble_cnt_o), 200'(0));
      m_ex = '0; m_cnt = 0;

      tab.push_back(row(mk(0,0,K_ADDI,9,8,0,5),  0, 1, 1, 8, 0));
      tab.push_back(row(mk(0,0,K_LW,9,8,0,4),    0, 1, 1, 8, 0));
      tab.push_back(row(mk(0,0,K_ADD,8,10,11,0), H, 1-H, 1-H, H ? 0 : 11, H));
      tab.push_back(row(mk(0,0,K_ADD,8,10,11,0), 0, 1, 1, 11, H));
      tab.push_back(row(mk(0,0,K_LW,9,0,0,8),    0, 1, 1, 0, H));
      tab.push_back(row(mk(0,0,K_ADD,0,0,12,0),  0, 1, 1, 12, H));
      tab.push_back(row(mk(0,0,K_LW,9,8,0,4),    0, 1, 1, 8, H));
      tab.push_back(row(mk(0,0,K_ADDI,9,8,0,1),  0, 1, 1, 8, H));
      tab.push_back(row(mk(0,0,K_LW,9,8,0,4),    0, 1, 1, 8, H));
      tab.push_back(row(mk(0,1,K_ADD,8,10,11,0), 0, 0, 0, 0, H));
      tab.push_back(row(mk(0,0,K_ADD,8,10,11,0), 0, 1, 1, 11, H));
      tab.push_back(row(mk(0,0,K_LW,1,8,0,0),    0, 1, 1, 8, H));
      tab.push_back(row(mk(0,0,K_LW,8,9,0,0),    H, 1-H, 1-H, H ? 0 : 9, 2*H));
      tab.push_back(row(mk(0,0,K_LW,8,9,0,0),    0, 1, 1, 9, 2*H));
      tab.push_back(row(mk(0,0,K_ADD,9,2,3,0),   H, 1-H, 1-H, H ? 0 : 3, 3*H));
      tab.push_back(row(mk(0,0,K_ADD,9,2,3,0),   0, 1, 1, 3, 3*H));
      tab.push_back(row(mk(0,0,K_LW,1,5,0,0),    0, 1, 1, 5, 3*H));
      tab.push_back(row(mk(0,0,K_SW,1,5,0,0),    H, 1-H, 0, H ? 0 : 5, 4*H));
      tab.push_back(row(mk(0,0,K_SW,1,5,0,0),    0, 1, 0, 5, 4*H));
      tab.push_back(row(mk(0,0,K_LW,1,6,0,0),    0, 1, 1, 6, 4*H));
      tab.push_back(row(mk(1,0,K_ADD,6,1,7,0),   H, 0, 0, 0, 0));
      tab.push_back(row(mk(0,0,K_ADD,6,1,7,0),   0, 1, 1, 7, 0));

      foreach (tab[k]) begin
         cur = tab[k].in;
         #1;
         chk($sformatf("vec%0d_stall", k), 200'(stall_o), 200'(tab[k].stall));
         step(s);
         chk($sformatf("vec%0d_valid", k), 200'(valid_o), 200'(tab[k].valid));
         chk($sformatf("vec%0d_regwrite", k), 200'(RegWrite_o), 200'(tab[k].rw));
         chk($sformatf("vec%0d_wr_reg", k), 200'(wr_reg_o), 200'(tab[k].wr));
         chk($sformatf("vec%0d_cnt", k), 200'(bubble_cnt_o), 200'(tab[k].cnt));
      end
      chk("vec_tail_imm_zero", 200'(imm_o), 200'(0));

      held = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (!held) begin
            cur.rw = 1'($urandom); cur.alusrc = 1'($urandom); cur.regdst = 1'($urandom);
            cur.branch = 1'($urandom); cur.memread = 1'($urandom);
            cur.memwrite = 1'($urandom); cur.memtoreg = 1'($urandom);
            cur.aluop = 3'($urandom);
            cur.rs = 5'($urandom_range(0, 3)); cur.rt = 5'($urandom_range(0, 3));
            cur.rd = 5'($urandom_range(0, 3));
            cur.rsd = $urandom; cur.rtd = $urandom; cur.imm = $urandom; cur.pc4 = $urandom;
            cur.funct = 6'($urandom);
         end
         cur.flush = ($urandom_range(0, 9) == 0);
         cur.rst = ($urandom_range(0, 79) == 0);
         #1;
         chk($sformatf("rnd%0d_stall", n), 200'(stall_o), 200'(model_stall(m_ex, cur)));
         step(s);
         held = s && !cur.rst;
         chk($sformatf("rnd%0d_ex", n), 200'(dut_ex), 200'(m_ex));
         chk($sformatf("rnd%0d_cnt", n), 200'(bubble_cnt_o), 200'(m_cnt));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
